i2s_receiver: RTL

I2S_RECEIVER -- requirements
Module: i2s_receiver

---
 rtl/i2s_receiver.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes BCK/LRCK/SIN into in_clk, frames stereo slots and
// delivers {left, right} sample pairs over a valid/ready handshake.
module i2s_receiver #(
    parameter int unsigned WORD_BITS = 16,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   in_clk,
    input  logic                   rst_n,
    input  logic                   bck,
    input  logic                   lrck,
    input  logic                   sin,
    output logic [2*WORD_BITS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   locked,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   bck_meta_q, bck_sync_q, bck_prev_q;
    logic                   lrck_meta_q, lrck_sync_q;
    logic                   sin_meta_q, sin_sync_q;
    logic                   lr_prev_q;
    logic [CNT_W-1:0]       slot_q, slot_d, slot_inc_c;
    logic [IDLE_W-1:0]      idle_q, idle_d, idle_inc_c;
    logic [WORD_BITS-1:0]   left_sr_q, right_sr_q, left_q;
    logic [1:0]             good_q;
    logic                   locked_q, frame_err_q, overrun_q, out_valid_q;
    logic [2*WORD_BITS-1:0] out_data_q;

    logic rise_c, lr_chg_c, shift_c, timeout_c;
    logic good_edge_c, ferr_c, latch_c, done_c;

    // Bit-clock edge, slot counter and idle watchdog
    always_comb begin
        rise_c     = bck_sync_q & ~bck_prev_q;
        lr_chg_c   = rise_c && (lrck_sync_q != lr_prev_q);
        slot_inc_c = (slot_q == '1) ? slot_q : slot_q + CNT_W'(1);
        slot_d     = slot_q;
        if (rise_c) begin
            slot_d = lr_chg_c ? '0 : slot_inc_c;
        end
        shift_c    = rise_c && !lr_chg_c && (slot_inc_c <= CNT_W'(WORD_BITS));
        idle_inc_c = (idle_q == IDLE_W'(TIMEOUT)) ? idle_q : idle_q + IDLE_W'(1);
        idle_d     = rise_c ? '0 : idle_inc_c;
        timeout_c  = !rise_c && (idle_inc_c == IDLE_W'(TIMEOUT));
    end

    // Framing state machine: next state and per-rise events
    always_comb begin
        state_d     = state_q;
        ferr_c      = 1'b0;
        latch_c     = 1'b0;
        done_c      = 1'b0;
        good_edge_c = lr_chg_c && (slot_q == CNT_W'(SLOT_BITS - 1)) &&
                      (lrck_sync_q == (state_q == LEFT));
        if (timeout_c) begin
            state_d = HUNT;
        end else if (rise_c) begin
            case (state_q)
                HUNT: begin
                    if (lr_chg_c && !lrck_sync_q) begin
                        state_d = LEFT;
                    end
                end
                LEFT, RIGHT: begin
                    if (good_edge_c) begin
                        latch_c = (state_q == LEFT);
                        done_c  = (state_q == RIGHT);
                        state_d = (state_q == LEFT) ? RIGHT : LEFT;
                    end else if (lr_chg_c || (slot_q == CNT_W'(SLOT_BITS - 1))) begin
                        ferr_c  = 1'b1;
                        state_d = (lr_chg_c && !lrck_sync_q) ? LEFT : HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            bck_meta_q  <= 1'b0;
            bck_sync_q  <= 1'b0;
            bck_prev_q  <= 1'b0;
            lrck_meta_q <= 1'b0;
            lrck_sync_q <= 1'b0;
            sin_meta_q  <= 1'b0;
            sin_sync_q  <= 1'b0;
            lr_prev_q   <= 1'b0;
            slot_q      <= '0;
            idle_q      <= '0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            left_q      <= '0;
            good_q      <= 2'd0;
            locked_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            bck_meta_q  <= bck;
            bck_sync_q  <= bck_meta_q;
            bck_prev_q  <= bck_sync_q;
            lrck_meta_q <= lrck;
            lrck_sync_q <= lrck_meta_q;
            sin_meta_q  <= sin;
            sin_sync_q  <= sin_meta_q;
            slot_q      <= slot_d;
            idle_q      <= idle_d;
            frame_err_q <= ferr_c;
            overrun_q   <= 1'b0;
            if (rise_c) begin
                lr_prev_q <= lrck_sync_q;
            end
            if (shift_c) begin
                if (lrck_sync_q) begin
                    right_sr_q <= {right_sr_q[WORD_BITS-2:0], sin_sync_q};
                end else begin
                    left_sr_q <= {left_sr_q[WORD_BITS-2:0], sin_sync_q};
                end
            end
            if (latch_c) begin
                left_q <= left_sr_q;
            end
            // Lock needs two back-to-back good frames since the last loss
            if (ferr_c || timeout_c) begin
                good_q   <= 2'd0;
                locked_q <= 1'b0;
            end else if (done_c) begin
                if (good_q != 2'd2) begin
                    good_q <= good_q + 2'd1;
                end
                if (good_q != 2'd0) begin
                    locked_q <= 1'b1;
                end
            end
            // Single-entry output holding register; a frame with nowhere to go is dropped
            if (done_c) begin
                if (!out_valid_q || out_ready) begin
                    out_data_q  <= {left_q, right_sr_q};
                    out_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
